// File: rtl/apb_bridge_pkg.sv
// Shared APB types and constants for the bridge and its register-file slave.
package apb_bridge_pkg;
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam logic [APB_DATA_W-1:0] APB_SLV_ID_BASE = 32'hA5B0_0000;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_slv_state_t;
endpackage

// File: rtl/apb_slv_wait_ctr.sv
// Loadable down-counter for APB wait states; saturates at zero and flags it.
module apb_slv_wait_ctr (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);
endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register file with WAIT_STATES registered wait cycles.
// APB_SLV_PSLVERR_EN: error responses plus read-only ID register at index DEPTH-1.
module apb_slave_regfile
  import apb_bridge_pkg::*;
#(
  parameter int SLAVE_ID    = 0,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [2:0]            psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  apb_slv_state_t        state;
  logic [APB_DATA_W-1:0] regs [DEPTH];
  logic [IW-1:0]         idx_q;
  logic                  wr_q;
  logic                  legal_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [3:0]            cnt;
  logic                  cnt_zero;

  logic                  sel;
  logic                  legal_in;
  logic [IW-1:0]         cur_idx;
  logic                  cur_wr;
  logic                  cur_legal;
  logic                  ro_c;
  logic                  ro_q;
  logic                  err_c;
  logic [APB_DATA_W-1:0] rd_c;
  logic                  start;
  logic                  step;

  assign sel      = psel[SLAVE_ID];
  assign legal_in = (paddr[1:0] == 2'b00) && (paddr[APB_ADDR_W-1:IW+2] == '0);
  assign start    = (state == IDLE) && sel && !penable;
  assign step     = (state != IDLE) && sel && penable && !cnt_zero;

  // With zero wait states the response is decided in the setup cycle,
  // before the address is latched, so look at the live bus there.
  always_comb begin
    cur_idx   = idx_q;
    cur_wr    = wr_q;
    cur_legal = legal_q;
    if (state == IDLE) begin
      cur_idx   = paddr[IW+1:2];
      cur_wr    = pwrite;
      cur_legal = legal_in;
    end
  end

  always_comb begin
    ro_c  = 1'b0;
    ro_q  = 1'b0;
    err_c = 1'b0;
    rd_c  = cur_legal ? regs[cur_idx] : '0;
`ifdef APB_SLV_PSLVERR_EN
    ro_c  = cur_legal && (cur_idx == LAST_IDX);
    ro_q  = idx_q == LAST_IDX;
    err_c = !cur_legal || (cur_wr && ro_c);
    if (ro_c) rd_c = APB_SLV_ID_BASE | APB_DATA_W'(SLAVE_ID);
`endif
  end

  apb_slv_wait_ctr u_wait_ctr (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .load     (start),
    .load_val (4'(WAIT_STATES)),
    .dec      (step),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      legal_q <= 1'b0;
      wdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            idx_q   <= paddr[IW+1:2];
            wr_q    <= pwrite;
            legal_q <= legal_in;
            wdata_q <= pwdata;
            if (WAIT_STATES == 0) begin
              pready  <= 1'b1;
              pslverr <= err_c;
              if (!pwrite) prdata <= rd_c;
            end
          end
        end
        default: begin
          if (!sel) begin
            state <= IDLE;
          end else if (!penable) begin
            pready  <= pready;
            pslverr <= pslverr;
          end else if (cnt_zero) begin
            // Completion cycle: commit the write at its closing edge.
            state <= IDLE;
            if (wr_q && legal_q && !ro_q) regs[idx_q] <= wdata_q;
          end else begin
            state <= ACCESS;
            if (cnt == 4'd1) begin
              pready  <= 1'b1;
              pslverr <= err_c;
              if (!wr_q) prdata <= rd_c;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three slaves with 1, 0 and 3 wait states on one bus.
module tb_apb_slave_regfile;
`ifdef APB_SLV_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [31:0] ID0 = 32'hA5B0_0000;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          is_rd;
  } exp_t;

  logic        hclk;
  logic        hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_w [3];
  logic [2:0]  pready_w;
  logic [2:0]  pslverr_w;

  int   checks = 0;
  int   errors = 0;
  int   ws [3] = '{1, 0, 3};
  exp_t sb [$];

  apb_slave_regfile #(.SLAVE_ID(0), .DEPTH(16), .WAIT_STATES(1)) u0 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]));
  apb_slave_regfile #(.SLAVE_ID(1), .DEPTH(16), .WAIT_STATES(0)) u1 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]));
  apb_slave_regfile #(.SLAVE_ID(2), .DEPTH(16), .WAIT_STATES(3)) u2 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer to slave s; leaves the bus driven so a following call is back-to-back.
  task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    int   k;
    bit   done;
    bit   other;
    e.rd = exp_rd; e.err = exp_err; e.is_rd = !wr;
    sb.push_back(e);
    @(posedge hclk); #1;
    psel = 3'(1 << s); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge hclk);
    chk("pready_low_in_setup", {31'd0, pready_w[s]}, 32'd0);
    @(posedge hclk); #1;
    penable = 1'b1;
    k = 0; done = 1'b0; other = 1'b0;
    while (!done && k < 20) begin
      @(negedge hclk);
      for (int j = 0; j < 3; j++) if (j != s && pready_w[j]) other = 1'b1;
      if (pready_w[s]) done = 1'b1;
      else begin
        @(posedge hclk); #1;
        k++;
      end
    end
    e = sb.pop_front();
    chk("transfer_completes", {31'd0, done}, 32'd1);
    if (done) begin
      chk("wait_states", k, ws[s]);
      chk("pslverr", {31'd0, pslverr_w[s]}, {31'd0, e.err});
      if (e.is_rd) chk("prdata", prdata_w[s], e.rd);
    end
    chk("no_response_from_others", {31'd0, other}, 32'd0);
  endtask

  task automatic bus_idle();
    @(posedge hclk); #1;
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  initial begin
    int  k;
    bit  done;
    bit  seen;
    hresetn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("reset_pready", {29'd0, pready_w}, 32'd0);
    chk("reset_pslverr", {29'd0, pslverr_w}, 32'd0);
    chk("reset_prdata0", prdata_w[0], 32'd0);
    chk("reset_prdata2", prdata_w[2], 32'd0);
    @(posedge hclk); #1 hresetn = 1'b1;

    for (int i = 0; i < 16; i++)
      xfer(0, 1'b0, 32'(i * 4), 32'd0, (ERR_EN && i == 15) ? ID0 : 32'd0, 1'b0);

    xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'd0, 1'b0);
    xfer(0, 1'b0, 32'h8, 32'd0, 32'hDEAD_BEEF, 1'b0);

    xfer(1, 1'b1, 32'h0, 32'h1, 32'd0, 1'b0);
    xfer(1, 1'b1, 32'h4, 32'h2, 32'd0, 1'b0);
    xfer(1, 1'b1, 32'hC, 32'h3, 32'd0, 1'b0);
    xfer(1, 1'b0, 32'h0, 32'd0, 32'h1, 1'b0);
    xfer(1, 1'b0, 32'h4, 32'd0, 32'h2, 1'b0);
    xfer(1, 1'b0, 32'hC, 32'd0, 32'h3, 1'b0);
    bus_idle();

    xfer(0, 1'b1, 32'h42, 32'h5, 32'd0, ERR_EN);
    xfer(0, 1'b1, 32'h400, 32'h77, 32'd0, ERR_EN);
    xfer(0, 1'b0, 32'h400, 32'd0, 32'd0, ERR_EN);
    xfer(0, 1'b0, 32'h0, 32'd0, 32'd0, 1'b0);
    xfer(0, 1'b0, 32'h3C, 32'd0, ERR_EN ? ID0 : 32'd0, 1'b0);
    xfer(0, 1'b1, 32'h3C, 32'h1234, 32'd0, ERR_EN);
    xfer(0, 1'b0, 32'h3C, 32'd0, ERR_EN ? ID0 : 32'h1234, 1'b0);
    bus_idle();

    // Wrong select: u1 is addressed, u0 must stay silent and unchanged.
    xfer(1, 1'b1, 32'h8, 32'h99, 32'd0, 1'b0);
    xfer(0, 1'b0, 32'h8, 32'd0, 32'hDEAD_BEEF, 1'b0);
    bus_idle();

    // Abort: drop psel while u2 is counting down its wait states.
    xfer(2, 1'b1, 32'h4, 32'h11, 32'd0, 1'b0);
    bus_idle();
    @(posedge hclk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55;
    @(posedge hclk); #1 penable = 1'b1;
    @(posedge hclk); #1;
    psel = 3'b000; penable = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge hclk);
      if (pready_w[2]) seen = 1'b1;
    end
    chk("abort_no_pready", {31'd0, seen}, 32'd0);
    xfer(2, 1'b0, 32'h4, 32'd0, 32'h11, 1'b0);
    bus_idle();

    // Reset asserted in the completion cycle of a read.
    @(posedge hclk); #1;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
    @(posedge hclk); #1 penable = 1'b1;
    k = 0; done = 1'b0;
    while (!done && k < 20) begin
      @(negedge hclk);
      if (pready_w[2]) done = 1'b1;
      else k++;
    end
    chk("rst_mid_read_reached_ready", {31'd0, done}, 32'd1);
    chk("rst_mid_read_data", prdata_w[2], 32'h11);
    #1 hresetn = 1'b0;
    #1;
    chk("rst_mid_pready", {29'd0, pready_w}, 32'd0);
    chk("rst_mid_prdata", prdata_w[2], 32'd0);
    chk("rst_mid_pslverr", {29'd0, pslverr_w}, 32'd0);
    psel = 3'b000; penable = 1'b0;
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;

    xfer(2, 1'b0, 32'h4, 32'd0, 32'd0, 1'b0);
    xfer(0, 1'b0, 32'h8, 32'd0, 32'd0, 1'b0);
    xfer(1, 1'b0, 32'h4, 32'd0, 32'd0, 1'b0);
    bus_idle();
    repeat (2) @(posedge hclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB slave register file sitting directly downstream of the APB interface stage. It consumes the bridge's `psel`/`penable`/`pwrite`/`paddr`/`pwdata` outputs and returns `prdata` plus a `pready`/`pslverr` completion handshake. It provides a bank of 32-bit read/write registers with a programmable number of wait states, so the bridge's read and write paths can be exercised against a real responder.

## Interface
Parameters:
- `SLAVE_ID`, default 0: index of the `psel` bit (0..2) that selects this slave.
- `DEPTH`, default 16: number of 32-bit registers; power of two, 2..256.
- `WAIT_STATES`, default 1: access-phase cycles with `pready`=0 before completion; range 0..15.

Ports:
- `hclk` input 1: clock, rising edge.
- `hresetn` input 1: reset, asynchronous, active-low.
- `psel` input 3: one-hot slave select; this slave uses `psel[SLAVE_ID]`.
- `penable` input 1: APB access-phase indicator.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 32: byte address.
- `pwdata` input 32: write data.
- `prdata` output 32: read data, registered.
- `pready` output 1: transfer completes in the current access cycle, registered.
- `pslverr` output 1: error response, valid only while `pready`=1, registered.

## Operation
- `sel` = `psel[SLAVE_ID]`. Word index = `paddr[log2(DEPTH)+1:2]`.
- An access is **legal** when `paddr[1:0]`=0 and `paddr[31:log2(DEPTH)+2]`=0.
- FSM states and transitions:
  - IDLE: `sel & !penable` → SETUP. Latch addr, write flag, wdata and legality. Load the wait counter with `WAIT_STATES`.
  - SETUP: `sel & penable` → ACCESS. `!sel` → IDLE.
  - ACCESS: decrement the counter while it is nonzero. At 0, drive `pready`=1 for exactly one cycle, then → IDLE.
  - In any state other than IDLE, `!sel` aborts to IDLE. An abort performs no write and does not pulse `pready`.
- Legal write: the register updates with the latched `pwdata` at the edge that ends the `pready`=1 cycle.
- Legal read: `prdata` is loaded with the register contents so that it is valid in the `pready`=1 cycle. `prdata` holds that value until the next read completes.
- Illegal access: no register change. `prdata` = 0 on reads. Error behaviour is set by the Configuration macro.
- Back-to-back transfers: a new SETUP is accepted in the cycle immediately after `pready`=1.
- Reset values: all registers 0, `prdata`=0, `pready`=0, `pslverr`=0, FSM = IDLE, counter = 0.
- Reset asserted mid-transfer: the transfer is discarded with no partial write, and all outputs return to their reset values immediately.

## Timing
- Setup cycle is T0 (`sel`=1, `penable`=0). Access begins at T1. `pready`=1 at T1+`WAIT_STATES`.
- Total transfer length is 2+`WAIT_STATES` cycles. With `WAIT_STATES`=0, `pready`=1 at T1.
- `pready` and `pslverr` are never asserted outside ACCESS and never for more than one consecutive cycle per transfer.
- Read-after-write to the same address in the next transfer returns the new data.

## Configuration
- `APB_SLV_PSLVERR_EN` defined:
  - Illegal accesses complete with `pslverr`=1 in the `pready` cycle.
  - Writes to register index `DEPTH-1` are read-only. They produce `pslverr`=1 with no update.
  - That register reads back the constant `32'hA5B0_0000 | SLAVE_ID`.
- `APB_SLV_PSLVERR_EN` undefined:
  - `pslverr` is tied to 0.
  - Illegal accesses complete silently.
  - Index `DEPTH-1` is an ordinary read/write register.

## Structure
- Shared package `apb_bridge_pkg` holds:
  - FSM state enum `apb_slv_state_t` (IDLE, SETUP, ACCESS).
  - `APB_DATA_W`=32 and `APB_ADDR_W`=32.
  - ID register constant `APB_SLV_ID_BASE`=`32'hA5B0_0000`.
- One sub-module, `apb_slv_wait_ctr`: loadable down-counter with a `zero` flag that implements the wait-state count.
- Storage is a flat register array inside `apb_slave_regfile`.

## Test plan
- Reset: release `hresetn`. All registers read back 0, and `pready`/`pslverr`/`prdata` are 0.
- Write then read, `WAIT_STATES`=1: write `32'hDEAD_BEEF` to `paddr`=`32'h8`. Read `32'h8` → `prdata`=`32'hDEAD_BEEF`, with `pready` high in the third cycle of each transfer.
- `WAIT_STATES`=0 back-to-back: writes to `0x0`, `0x4`, `0xC` with `32'h1`, `32'h2`, `32'h3`, each completing in 2 cycles. Reads return 1, 2, 3.
- Illegal address with macro defined:
  - Write to `paddr`=`32'h42` → `pslverr`=1 in the `pready` cycle.
  - Write to `32'h400` (`DEPTH`=16) → `pslverr`=1 in the `pready` cycle, and no register changes.
  - Read of `0x3C` returns `32'hA5B0_0000 | SLAVE_ID`.
- Abort and reset mid-transfer:
  - Drop `psel` during ACCESS of a write of `32'h55` to `0x4` → no `pready`, and `0x4` keeps its old value.
  - Assert `hresetn`=0 mid-read → `pready` clears immediately and all registers are 0.
- Wrong select: `psel`=`3'b010` with `SLAVE_ID`=0 → no response and no write.
